// File: rtl/demod_segment_serializer.sv
// Captures one frame of demodulated segments on the rising edge of seg_valid and
// streams it out word by word over a valid/ready handshake, segment 0 first.
module demod_segment_serializer #(
    parameter int SEG_WIDTH   = 32,
    parameter int NUM_SEG     = 10,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SEG*SEG_WIDTH-1:0] seg_bus,
    input  logic                         seg_valid,
    output logic                         busy,
    output logic [SEG_WIDTH-1:0]         out_data,
    output logic [3:0]                   out_index,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         frame_done,
    output logic                         overrun,
    output logic [FRAME_CNT_W-1:0]       frame_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_SEG - 1);

    state_t               state;
    logic                 seg_valid_d;
    logic                 rise;
    logic [3:0]           idx_next;
    logic [SEG_WIDTH-1:0] frame_buf [NUM_SEG];

    assign rise     = seg_valid & ~seg_valid_d;
    assign idx_next = out_index + 4'd1;

    // out_data is reloaded from the frame buffer only on acceptance, so it holds
    // through any length of backpressure and never sees seg_bus outside the rise cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            seg_valid_d <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_index   <= '0;
            out_data    <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            seg_valid_d <= seg_valid;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        for (int unsigned k = 0; k < NUM_SEG; k++) begin
                            frame_buf[k] <= seg_bus[k*SEG_WIDTH +: SEG_WIDTH];
                        end
                        out_data  <= seg_bus[SEG_WIDTH-1:0];
                        out_index <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (rise) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FRAME_CNT_W'(1);
                        end else begin
                            out_index <= idx_next;
                            out_data  <= frame_buf[idx_next];
                            out_last  <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demod_segment_serializer.sv
// Randomized and directed bench for demod_segment_serializer, checked every cycle
// against a queue-based model of the frame stream.
module tb_demod_segment_serializer;

    localparam int SW = 32;
    localparam int NS = 10;
    localparam int FW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NS*SW-1:0]  seg_bus = '0;
    logic              seg_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [SW-1:0]     out_data;
    logic [3:0]        out_index;
    logic              out_valid;
    logic              out_last;
    logic              frame_done;
    logic              overrun;
    logic [FW-1:0]     frame_count;

    int checks = 0;
    int failures = 0;

    // Model: words still owed downstream, plus frame-level bookkeeping.
    logic [SW-1:0] q[$];
    logic          m_prev = 1'b0;
    logic          m_over = 1'b0;
    logic          m_done = 1'b0;
    int            m_frames = 0;

    always #5 clk = ~clk;

    demod_segment_serializer #(
        .SEG_WIDTH  (SW),
        .NUM_SEG    (NS),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_bus    (seg_bus),
        .seg_valid  (seg_valid),
        .busy       (busy),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_pattern(input logic [SW-1:0] base);
        for (int k = 0; k < NS; k++) seg_bus[k*SW +: SW] = base + SW'(k);
    endtask

    task automatic randomize_bus();
        for (int k = 0; k < NS; k++) seg_bus[k*SW +: SW] = $urandom;
    endtask

    task automatic step(input logic v, input logic r, input logic rst);
        logic rise;
        seg_valid = v;
        out_ready = r;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_prev   = 1'b0;
            m_over   = 1'b0;
            m_done   = 1'b0;
            m_frames = 0;
        end else begin
            rise   = v && !m_prev;
            m_prev = v;
            m_done = 1'b0;
            if (q.size() != 0) begin
                if (rise) m_over = 1'b1;
                if (r) begin
                    q.delete(0);
                    if (q.size() == 0) begin
                        m_done = 1'b1;
                        m_frames++;
                    end
                end
            end else if (rise) begin
                for (int k = 0; k < NS; k++) q.push_back(seg_bus[k*SW +: SW]);
            end
        end
        #1;
        check("busy", 64'(busy), 64'(q.size() != 0));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("frame_done", 64'(frame_done), 64'(m_done));
        check("frame_count", 64'(frame_count), 64'(m_frames % (1 << FW)));
        check("overrun", 64'(overrun), 64'(m_over));
        if (q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(q[0]));
            check("out_index", 64'(out_index), 64'(NS - q.size()));
            check("out_last", 64'(out_last), 64'(q.size() == 1));
        end
        if (rst) begin
            check("rst_out_data", 64'(out_data), 64'(0));
            check("rst_out_index", 64'(out_index), 64'(0));
            check("rst_out_last", 64'(out_last), 64'(0));
        end
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Plain frame, ready held high
        set_pattern(32'h1000_0000);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);
        check("frames_after_first", 64'(frame_count), 64'(1));

        // Backpressure for 3 cycles while index 4 is presented
        set_pattern(32'h2000_0000);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        check("stall_index", 64'(out_index), 64'(4));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("stall_hold_index", 64'(out_index), 64'(4));
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);

        // seg_valid held high for 40 cycles: one frame only
        step(1'b0, 1'b1, 1'b1);
        set_pattern(32'h3000_0000);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("level_frames", 64'(frame_count), 64'(1));
        check("level_overrun", 64'(overrun), 64'(0));

        // Second rise while index 2 is streaming
        set_pattern(32'h4000_0000);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        set_pattern(32'h5000_0000);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        check("overrun_sticky", 64'(overrun), 64'(1));

        // Rise on the cycle the last word is accepted is dropped
        set_pattern(32'h5800_0000);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Reset while index 5 is streaming
        step(1'b0, 1'b1, 1'b1);
        set_pattern(32'h6000_0000);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        check("pre_reset_index", 64'(out_index), 64'(5));
        step(1'b0, 1'b1, 1'b1);
        set_pattern(32'h7000_0000);
        step(1'b1, 1'b1, 1'b0);
        check("fresh_index", 64'(out_index), 64'(0));
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);

        // Back-to-back frames at minimum spacing, counter wraps
        step(1'b0, 1'b1, 1'b1);
        for (int f = 0; f < (1 << FW) + 1; f++) begin
            randomize_bus();
            step(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < NS; i++) step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("wrap_count", 64'(frame_count), 64'(1));
        check("wrap_overrun", 64'(overrun), 64'(0));

        // Random traffic
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic v;
            randomize_bus();
            v = ($urandom_range(0, 7) == 0) ? ~seg_valid : seg_valid;
            step(v, $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
